// File: rtl/reg_file_scoreboard.sv
// Register file with a per-register pending (scoreboard) bit and a pending-register counter.
// Latency: reads and busy flags are combinational; writes, pending bits and PendingCount update on the next rising clk.
// Backpressure: none; every write and issue is accepted on the edge it is presented.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   RegWrite/WriteRegister/WriteData  write port; a write also retires the register's pending producer
//   ReadRegister1/2 -> ReadData1/2  combinational read ports (optional same-cycle write bypass)
//   IssueValid/IssueRegister        marks a destination register as having an outstanding producer
//   Busy1/Busy2                     read register still waits on a producer
//   PendingCount                    registered popcount of the pending bits
module reg_file_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRegister,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic wr_ok;
    logic iss_ok;
    logic inc;
    logic dec;
    logic hit1, hit2;

    // Next-state for the array, pending bits and counter.
    always_comb begin
        wr_ok     = RegWrite && !((ZERO_REG != 0) && (WriteRegister == '0));
        iss_ok    = IssueValid && !((ZERO_REG != 0) && (IssueRegister == '0));
        regs_d    = regs_q;
        pending_d = pending_q;

        if (wr_ok) begin
            regs_d[WriteRegister]    = WriteData;
            pending_d[WriteRegister] = 1'b0;
        end
        // Applied after the clear so a new producer supersedes the retiring one.
        if (iss_ok) begin
            pending_d[IssueRegister] = 1'b1;
        end

        // Counter tracks the popcount incrementally: a set only counts if the bit was
        // clear, a clear only counts if the bit was set and is not re-set on this edge.
        inc     = iss_ok && !pending_q[IssueRegister];
        dec     = wr_ok && pending_q[WriteRegister]
                  && !(iss_ok && (IssueRegister == WriteRegister));
        count_d = count_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Read ports: hard zero register first, then the bypass, then array contents.
    always_comb begin
        hit1 = (BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister1);
        hit2 = (BYPASS != 0) && wr_ok && (WriteRegister == ReadRegister2);

        if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
            ReadData1 = '0;
        end else if (hit1) begin
            ReadData1 = WriteData;
        end else begin
            ReadData1 = regs_q[ReadRegister1];
        end

        if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
            ReadData2 = '0;
        end else if (hit2) begin
            ReadData2 = WriteData;
        end else begin
            ReadData2 = regs_q[ReadRegister2];
        end

        // A write in flight this cycle satisfies the consumer when bypassing.
        // Register 0 never has its pending bit set when it is hard-wired.
        Busy1 = pending_q[ReadRegister1]
                && !((BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister1));
        Busy2 = pending_q[ReadRegister2]
                && !((BYPASS != 0) && RegWrite && (WriteRegister == ReadRegister2));
    end

    assign PendingCount = count_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueRegister;
    logic              Busy1;
    logic              Busy2;
    logic [ADDR_W:0]   PendingCount;

    reg_file_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .IssueValid(IssueValid), .IssueRegister(IssueRegister),
        .Busy1(Busy1), .Busy2(Busy2), .PendingCount(PendingCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_mem  [DEPTH];
    bit          m_pend [DEPTH];

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (RegWrite && int'(WriteRegister) == a) return WriteData;
        return m_mem[a];
    endfunction

    function automatic bit m_busy(input int a);
        return m_pend[a] && !(RegWrite && int'(WriteRegister) == a);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic void m_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (RegWrite && WriteRegister != 0) begin
                m_mem[WriteRegister]  = WriteData;
                m_pend[WriteRegister] = 1'b0;
            end
            if (IssueValid && IssueRegister != 0) m_pend[IssueRegister] = 1'b1;
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        chk;      // compare combinational outputs before the edge
        bit        rst;
        bit        we;
        int        wr;
        logic [31:0] wd;
        int        rr1;
        int        rr2;
        bit        iv;
        int        ir;
        logic [31:0] rd1;
        logic [31:0] rd2;
        bit        b1;
        bit        b2;
        int        cnt;      // PendingCount after the edge
    } vec_t;

    vec_t vecs [17];

    task automatic drive(input bit r, input bit we, input int wr, input logic [31:0] wd,
                         input int rr1, input int rr2, input bit iv, input int ir);
        rst           = r;
        RegWrite      = we;
        WriteRegister = ADDR_W'(wr);
        WriteData     = wd;
        ReadRegister1 = ADDR_W'(rr1);
        ReadRegister2 = ADDR_W'(rr2);
        IssueValid    = iv;
        IssueRegister = ADDR_W'(ir);
    endtask

    // Comb outputs are sampled at the falling edge, registered outputs 1 time unit
    // after the rising edge; inputs change right after that.
    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0]  = '{0,1,0,0,32'h0,        7,31,0,0, 32'h0,        32'h0,        0,0,0};
        vecs[1]  = '{1,0,0,0,32'h0,        7,31,0,0, 32'h0,        32'h0,        0,0,0};
        vecs[2]  = '{1,0,1,5,32'hDEADBEEF, 5, 0,0,0, 32'hDEADBEEF, 32'h0,        0,0,0};
        vecs[3]  = '{1,0,0,0,32'h0,        5, 5,0,0, 32'hDEADBEEF, 32'hDEADBEEF, 0,0,0};
        vecs[4]  = '{1,0,1,0,32'h1234,     0, 5,1,0, 32'h0,        32'hDEADBEEF, 0,0,0};
        vecs[5]  = '{1,0,0,0,32'h0,        3, 0,1,3, 32'h0,        32'h0,        0,0,1};
        vecs[6]  = '{1,0,0,0,32'h0,        3, 3,1,3, 32'h0,        32'h0,        1,1,1};
        vecs[7]  = '{1,0,1,3,32'h55,       3, 5,0,0, 32'h55,       32'hDEADBEEF, 0,0,0};
        vecs[8]  = '{1,0,0,0,32'h0,        3, 9,0,0, 32'h55,       32'h0,        0,0,0};
        vecs[9]  = '{1,0,1,9,32'hAA,       9, 3,1,9, 32'hAA,       32'h55,       0,0,1};
        vecs[10] = '{1,0,0,0,32'h0,        9, 0,0,0, 32'hAA,       32'h0,        1,0,1};
        vecs[11] = '{1,0,0,0,32'h0,        1, 9,1,1, 32'h0,        32'hAA,       0,1,2};
        vecs[12] = '{1,0,0,0,32'h0,        1, 2,1,2, 32'h0,        32'h0,        1,0,3};
        vecs[13] = '{1,0,0,0,32'h0,        2, 4,1,4, 32'h0,        32'h0,        1,0,4};
        vecs[14] = '{1,1,1,2,32'h77,       2, 4,1,6, 32'h77,       32'h0,        0,1,0};
        vecs[15] = '{1,0,0,0,32'h0,        2, 4,0,0, 32'h0,        32'h0,        0,0,0};
        vecs[16] = '{1,0,0,0,32'h0,        9, 5,0,0, 32'h0,        32'h0,        0,0,0};

        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd,
                  vecs[i].rr1, vecs[i].rr2, vecs[i].iv, vecs[i].ir);
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d ReadData1", i), ReadData1, vecs[i].rd1);
                check($sformatf("vec%0d ReadData2", i), ReadData2, vecs[i].rd2);
                check($sformatf("vec%0d Busy1", i), 32'(Busy1), 32'(vecs[i].b1));
                check($sformatf("vec%0d Busy2", i), 32'(Busy2), 32'(vecs[i].b2));
            end
            tick();
            check($sformatf("vec%0d PendingCount", i), 32'(PendingCount), 32'(vecs[i].cnt));
        end

        // ---------------- counter saturation corner: fill every issuable register ----------------
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int r = 1; r < DEPTH; r++) begin
            drive(0, 0, 0, 0, r, 0, 1, r);
            tick();
        end
        check("fill PendingCount", 32'(PendingCount), 32'(DEPTH - 1));
        drive(0, 0, 0, 0, 31, 0, 1, 31);   // re-issue of a pending register
        tick();
        check("reissue PendingCount", 32'(PendingCount), 32'(DEPTH - 1));
        drive(0, 0, 0, 0, 31, 0, 1, 0);    // issue to hard-wired zero register
        @(negedge clk);
        check("full Busy1 r31", 32'(Busy1), 32'h1);
        tick();
        check("r0 issue PendingCount", 32'(PendingCount), 32'(DEPTH - 1));
        drive(0, 1, 17, 32'h1717, 17, 31, 0, 0);   // retire one producer
        tick();
        check("retire PendingCount", 32'(PendingCount), 32'(DEPTH - 2));
        drive(0, 0, 0, 0, 17, 31, 0, 0);
        @(negedge clk);
        check("retired Busy1", 32'(Busy1), 32'h0);
        check("retired ReadData1", ReadData1, 32'h1717);
        check("other Busy2", 32'(Busy2), 32'h1);

        // ---------------- randomized run against the reference model ----------------
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 2000; n++) begin
            bit narrow;
            int lim;
            narrow = ($urandom_range(0, 1) == 1);
            lim    = narrow ? 7 : DEPTH - 1;
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom_range(0, lim), $urandom,
                  $urandom_range(0, lim), $urandom_range(0, lim),
                  ($urandom_range(0, 1) == 0), $urandom_range(0, lim));
            @(negedge clk);
            check("rnd ReadData1", ReadData1, m_read(int'(ReadRegister1)));
            check("rnd ReadData2", ReadData2, m_read(int'(ReadRegister2)));
            check("rnd Busy1", 32'(Busy1), 32'(m_busy(int'(ReadRegister1))));
            check("rnd Busy2", 32'(Busy2), 32'(m_busy(int'(ReadRegister2))));
            tick();
            check("rnd PendingCount", 32'(PendingCount), 32'(m_count()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 5, meaning register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL provide parameter ZERO_REG, default 1, meaning that when 1, register 0 reads as zero, ignores writes and is never pending.
REQ-004 The block SHALL provide parameter BYPASS, default 1, meaning that when 1, same-cycle write data is forwarded to read ports.
REQ-005 Port list (name direction width meaning):
 clk  input  1  single clock; all state updates on rising edge
 rst  input  1  synchronous, active-high reset
 RegWrite  input  1  write enable
 WriteRegister  input  ADDR_W  write address
 WriteData  input  DATA_W  write data
 ReadRegister1  input  ADDR_W  read port 1 address
 ReadRegister2  input  ADDR_W  read port 2 address
 ReadData1  output  DATA_W  read port 1 data
 ReadData2  output  DATA_W  read port 2 data
 IssueValid  input  1  mark destination register pending
 IssueRegister  input  ADDR_W  destination being issued
 Busy1  output  1  ReadRegister1 has an outstanding producer
 Busy2  output  1  ReadRegister2 has an outstanding producer
 PendingCount  output  ADDR_W+1  number of pending registers

Function
REQ-006 On a rising clk with RegWrite=1 and rst=0, the block SHALL store WriteData into WriteRegister, except register 0 when ZERO_REG=1.
REQ-007 Reads SHALL be combinational, with ReadDataN equal to the array content at ReadRegisterN.
REQ-008 When BYPASS=1, RegWrite=1 and WriteRegister==ReadRegisterN (excluding register 0 when ZERO_REG=1), ReadDataN SHALL equal WriteData in the same cycle.
REQ-009 When BYPASS=0, ReadDataN SHALL show the old value until the cycle after the write.
REQ-010 When ZERO_REG=1, ReadDataN SHALL be 0 whenever ReadRegisterN==0, regardless of the write port.
REQ-011 The block SHALL hold one pending bit per register.
REQ-012 A rising edge with IssueValid=1 SHALL set pending[IssueRegister].
REQ-013 A rising edge with RegWrite=1 SHALL clear pending[WriteRegister].
REQ-014 If set and clear target the same register on the same edge, set SHALL win and the bit ends at 1, because a new producer supersedes the old one.
REQ-015 IssueValid to register 0 with ZERO_REG=1 SHALL be ignored.
REQ-016 A write to a non-pending register SHALL be legal and SHALL leave the pending bit at 0.
REQ-017 BusyN SHALL be combinational: pending[ReadRegisterN] AND NOT (BYPASS=1 AND RegWrite=1 AND WriteRegister==ReadRegisterN).
REQ-018 With BYPASS=0, BusyN SHALL equal pending[ReadRegisterN] only.
REQ-019 BusyN SHALL be 0 for register 0 when ZERO_REG=1.
REQ-020 PendingCount SHALL be a registered counter equal to the popcount of the pending bits after each edge.
REQ-021 PendingCount SHALL update by +1, -1 or 0 per edge, per REQ-012..REQ-015; it SHALL never wrap, with maximum 2**ADDR_W (or 2**ADDR_W-1 when ZERO_REG=1).
REQ-022 Re-issuing an already pending register SHALL not change PendingCount.

Reset
REQ-023 On a rising clk with rst=1, all registers SHALL become 0, all pending bits SHALL become 0, and PendingCount SHALL become 0.
REQ-024 rst SHALL take priority over RegWrite and IssueValid on the same edge; outstanding issues are discarded.
REQ-025 After reset with all inputs idle, ReadData1/2 SHALL be 0 and Busy1/2 SHALL be 0; contents before the first reset are undefined.

Verification
REQ-026 Scenario: rst 1 cycle, then read r7 and r31 -> ReadData=0, Busy=0, PendingCount=0.
REQ-027 Scenario: write r5=0xDEADBEEF while ReadRegister1=5 in the same cycle -> ReadData1=0xDEADBEEF that cycle (BYPASS=1), and still 0xDEADBEEF next cycle.
REQ-028 Scenario: write r0=0x1234 and IssueValid on r0 (ZERO_REG=1) -> ReadData1 at r0 = 0, Busy1=0, PendingCount unchanged.
REQ-029 Scenario: issue r3, then r3 again, then write r3=0x55 -> Busy=1 after the first edge, PendingCount 1,1,0, Busy drops in the write cycle, ReadData=0x55.
REQ-030 Scenario: issue r9 and write r9=0xAA on the same edge -> pending[r9]=1, PendingCount +1, register holds 0xAA.
REQ-031 Scenario: issue r1, r2, r4, then assert rst together with a write to r2 -> PendingCount=0, r2=0, all Busy=0.
